// File: rtl/div_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : div_scheduler
// Description : Multi-cycle radix-2 restoring divide sequencer for RV32IM with
//               hazard-overlap signalling and a held writeback result.
// Revision    : 1.0 - initial release
// ============================================================================
module div_scheduler #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_E,
  input  logic [1:0]      funct_E,
  input  logic [XLEN-1:0] rs1_val_E,
  input  logic [XLEN-1:0] rs2_val_E,
  input  logic [4:0]      rd_E,
  input  logic [4:0]      rs1_D,
  input  logic [4:0]      rs2_D,
  input  logic [4:0]      rd_D,
  input  logic            RegWrite_D,
  input  logic            div_D,
  input  logic            wb_free,
  output logic            div_stall,
  output logic            div_overlap,
  output logic            div_wb_valid,
  output logic [4:0]      div_wb_rd,
  output logic [XLEN-1:0] div_wb_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int              c_cw      = $clog2(XLEN);
  localparam logic [c_cw-1:0] c_last    = c_cw'(XLEN - 1);
  localparam logic [XLEN-1:0] c_int_min = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] c_all_one = {XLEN{1'b1}};

  state_t            r_state;
  logic [c_cw-1:0]   r_count;
  logic [2*XLEN-1:0] r_rq;
  logic [XLEN-1:0]   r_divisor;
  logic [1:0]        r_funct;
  logic [4:0]        r_rd;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_wb_valid;
  logic [4:0]        r_wb_rd;
  logic [XLEN-1:0]   r_wb_data;

  // ---------------------------------------------------------------------
  // Operand preparation for an op arriving from EX
  // ---------------------------------------------------------------------
  logic            w_signed_E;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_div_zero;
  logic            w_ovf;
  logic [XLEN-1:0] w_special;

  always_comb begin
    w_signed_E = ~funct_E[0];
    w_a_neg    = w_signed_E & rs1_val_E[XLEN-1];
    w_b_neg    = w_signed_E & rs2_val_E[XLEN-1];
    w_a_mag    = w_a_neg ? -rs1_val_E : rs1_val_E;
    w_b_mag    = w_b_neg ? -rs2_val_E : rs2_val_E;
    w_div_zero = (rs2_val_E == '0);
    w_ovf      = w_signed_E & (rs1_val_E == c_int_min) & (rs2_val_E == c_all_one);
    // Divide-by-zero takes precedence; it already covers the REM-by-zero case.
    if (funct_E[1]) begin
      w_special = w_div_zero ? rs1_val_E : '0;
    end else begin
      w_special = w_div_zero ? c_all_one : c_int_min;
    end
  end

  // ---------------------------------------------------------------------
  // One restoring iteration: shift, trial subtract, set quotient bit
  // ---------------------------------------------------------------------
  logic [XLEN:0]   w_upper;
  logic            w_fits;
  logic [XLEN-1:0] w_rem_next;
  logic [XLEN-1:0] w_quo_next;
  logic [XLEN-1:0] w_quo_fix;
  logic [XLEN-1:0] w_rem_fix;
  logic [XLEN-1:0] w_final;

  always_comb begin
    w_upper    = r_rq[2*XLEN-1:XLEN-1];
    w_fits     = (w_upper >= {1'b0, r_divisor});
    // When the trial fits the difference is below the divisor, so XLEN bits hold it.
    w_rem_next = w_fits ? (w_upper[XLEN-1:0] - r_divisor) : w_upper[XLEN-1:0];
    w_quo_next = {r_rq[XLEN-2:0], w_fits};
    w_quo_fix  = r_neg_q ? -w_quo_next : w_quo_next;
    w_rem_fix  = r_neg_r ? -w_rem_next : w_rem_next;
    w_final    = r_funct[1] ? w_rem_fix : w_quo_fix;
  end

  // ---------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_rq       <= '0;
      r_divisor  <= '0;
      r_funct    <= '0;
      r_rd       <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_E) begin
            r_funct   <= funct_E;
            r_rd      <= rd_E;
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
            r_divisor <= w_b_mag;
            r_count   <= '0;
            if (w_div_zero || w_ovf) begin
              r_state    <= S_DONE;
              r_rq       <= '0;
              r_wb_valid <= (rd_E != 5'd0);
              r_wb_rd    <= rd_E;
              r_wb_data  <= w_special;
            end else begin
              r_state <= S_CALC;
              r_rq    <= {{XLEN{1'b0}}, w_a_mag};
            end
          end
        end

        S_CALC: begin
          r_rq    <= {w_rem_next, w_quo_next};
          r_count <= r_count + 1'b1;
          if (r_count == c_last) begin
            r_state    <= S_DONE;
            r_count    <= '0;
            r_wb_valid <= (r_rd != 5'd0);
            r_wb_rd    <= r_rd;
            r_wb_data  <= w_final;
          end
        end

        S_DONE: begin
          // A discarded (rd == x0) result leaves without waiting for the port.
          if (wb_free || !r_wb_valid) begin
            r_state    <= S_IDLE;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Hazard-unit interface
  // ---------------------------------------------------------------------
  logic [4:0] w_active_rd;
  logic       w_hazard;

  always_comb begin
    w_active_rd = (r_state == S_IDLE) ? rd_E : r_rd;
    w_hazard    = (w_active_rd != 5'd0) &&
                  ((rs1_D == w_active_rd) || (rs2_D == w_active_rd) ||
                   (RegWrite_D && (rd_D == w_active_rd)));
    div_stall   = start_E | (r_state != S_IDLE);
    div_overlap = div_stall & ~div_D & ~w_hazard;
  end

  assign div_wb_valid = r_wb_valid;
  assign div_wb_rd    = r_wb_rd;
  assign div_wb_data  = r_wb_data;

endmodule
`default_nettype wire

// File: tb/tb_div_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_scheduler
// Description : Directed, table-driven self-checking bench for div_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_scheduler;

  logic        clk;
  logic        rst;
  logic        start_E;
  logic [1:0]  funct_E;
  logic [31:0] rs1_val_E;
  logic [31:0] rs2_val_E;
  logic [4:0]  rd_E;
  logic [4:0]  rs1_D;
  logic [4:0]  rs2_D;
  logic [4:0]  rd_D;
  logic        RegWrite_D;
  logic        div_D;
  logic        wb_free;
  logic        div_stall;
  logic        div_overlap;
  logic        div_wb_valid;
  logic [4:0]  div_wb_rd;
  logic [31:0] div_wb_data;

  int checks = 0;
  int errors = 0;

  div_scheduler #(.XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_E      (start_E),
    .funct_E      (funct_E),
    .rs1_val_E    (rs1_val_E),
    .rs2_val_E    (rs2_val_E),
    .rd_E         (rd_E),
    .rs1_D        (rs1_D),
    .rs2_D        (rs2_D),
    .rd_D         (rd_D),
    .RegWrite_D   (RegWrite_D),
    .div_D        (div_D),
    .wb_free      (wb_free),
    .div_stall    (div_stall),
    .div_overlap  (div_overlap),
    .div_wb_valid (div_wb_valid),
    .div_wb_rd    (div_wb_rd),
    .div_wb_data  (div_wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    @(negedge clk);
    funct_E   = f;
    rs1_val_E = a;
    rs2_val_E = b;
    rd_E      = rd;
    start_E   = 1'b1;
  endtask

  // Called right after the launch edge (#1 in T+1); returns cycles until valid.
  task automatic wait_valid(output int n, output logic stall_gap);
    n = 1;
    stall_gap = 1'b0;
    while (!div_wb_valid && n < 100) begin
      if (!div_stall) stall_gap = 1'b1;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic do_div(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int exp_lat,
                        input string tag);
    int   n;
    logic gap;
    launch(f, a, b, rd);
    #1;
    check($sformatf("%s_stall_T", tag), {31'b0, div_stall}, 32'd1);
    @(posedge clk); #1;
    start_E = 1'b0;
    wait_valid(n, gap);
    check($sformatf("%s_latency", tag), 32'(n), 32'(exp_lat));
    check($sformatf("%s_data", tag), div_wb_data, exp);
    check($sformatf("%s_rd", tag), {27'b0, div_wb_rd}, {27'b0, rd});
    check($sformatf("%s_stall_busy", tag), {31'b0, gap | ~div_stall}, 32'd0);
    @(posedge clk); #1;
    check($sformatf("%s_idle_valid", tag), {31'b0, div_wb_valid}, 32'd0);
    check($sformatf("%s_idle_stall", tag), {31'b0, div_stall}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int   n;
    logic gap;
    logic seen;
    logic bad;

    vecs[0]  = '{2'b01, 32'd100,        32'd7,          5'd5,  32'd14,         33};
    vecs[1]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFD,  33};
    vecs[2]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          5'd7,  32'hFFFF_FFFF,  33};
    vecs[3]  = '{2'b11, 32'hFFFF_FFFF,  32'd16,         5'd8,  32'd15,         33};
    vecs[4]  = '{2'b00, 32'h0000_1234,  32'd0,          5'd9,  32'hFFFF_FFFF,  1};
    vecs[5]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  5'd10, 32'd0,          1};
    vecs[6]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'h8000_0000,  1};
    vecs[7]  = '{2'b11, 32'h0000_0055,  32'd0,          5'd12, 32'h0000_0055,  1};
    vecs[8]  = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'd0,          33};
    vecs[9]  = '{2'b00, 32'd7,          32'hFFFF_FFFE,  5'd14, 32'hFFFF_FFFD,  33};
    vecs[10] = '{2'b10, 32'd7,          32'hFFFF_FFFE,  5'd15, 32'd1,          33};
    vecs[11] = '{2'b01, 32'hFFFF_FFFF,  32'd1,          5'd16, 32'hFFFF_FFFF,  33};
    vecs[12] = '{2'b00, 32'h8000_0000,  32'd2,          5'd17, 32'hC000_0000,  33};
    vecs[13] = '{2'b10, 32'hFFFF_FFF8,  32'd3,          5'd31, 32'hFFFF_FFFE,  33};

    rst = 1'b1; start_E = 1'b0; funct_E = 2'b00; rs1_val_E = '0; rs2_val_E = '0;
    rd_E = '0; rs1_D = '0; rs2_D = '0; rd_D = '0; RegWrite_D = 1'b0; div_D = 1'b0;
    wb_free = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid",   {31'b0, div_wb_valid}, 32'd0);
    check("reset_rd",      {27'b0, div_wb_rd},    32'd0);
    check("reset_data",    div_wb_data,           32'd0);
    check("reset_stall",   {31'b0, div_stall},    32'd0);
    check("reset_overlap", {31'b0, div_overlap},  32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      do_div(vecs[i].funct, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].lat,
             $sformatf("vec%0d", i));
    end

    // Overlap decisions while a divide to x5 is starting and in flight.
    launch(2'b01, 32'd100, 32'd7, 5'd5);
    rs1_D = 5'd6; #1;
    check("ovl_T_rs6", {31'b0, div_overlap}, 32'd1);
    rs1_D = 5'd5; #1;
    check("ovl_T_rs5", {31'b0, div_overlap}, 32'd0);
    @(posedge clk); #1;
    start_E = 1'b0;
    rs1_D = 5'd6; #1;
    check("ovl_rs1_x6", {31'b0, div_overlap}, 32'd1);
    rs1_D = 5'd5; #1;
    check("ovl_rs1_x5", {31'b0, div_overlap}, 32'd0);
    rs1_D = 5'd0; rs2_D = 5'd5; #1;
    check("ovl_rs2_x5", {31'b0, div_overlap}, 32'd0);
    rs2_D = 5'd0; rd_D = 5'd5; RegWrite_D = 1'b1; #1;
    check("ovl_waw_x5", {31'b0, div_overlap}, 32'd0);
    RegWrite_D = 1'b0; #1;
    check("ovl_rd_nowrite", {31'b0, div_overlap}, 32'd1);
    div_D = 1'b1; #1;
    check("ovl_second_div", {31'b0, div_overlap}, 32'd0);
    div_D = 1'b0; rd_D = 5'd0;
    wait_valid(n, gap);
    check("ovl_div_data", div_wb_data, 32'd14);
    @(posedge clk); #1;
    check("ovl_div_overlap_idle", {31'b0, div_overlap}, 32'd0);

    // Divide to x0: runs to completion but never claims the writeback port.
    launch(2'b01, 32'd100, 32'd7, 5'd0);
    @(posedge clk); #1;
    start_E = 1'b0;
    rs1_D = 5'd0; rs2_D = 5'd0; rd_D = 5'd0; RegWrite_D = 1'b1; #1;
    check("rd0_overlap", {31'b0, div_overlap}, 32'd1);
    div_D = 1'b1; #1;
    check("rd0_overlap_div", {31'b0, div_overlap}, 32'd0);
    div_D = 1'b0; RegWrite_D = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (div_wb_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("rd0_no_valid", {31'b0, seen}, 32'd0);
    check("rd0_back_idle", {31'b0, div_stall}, 32'd0);

    // Writeback port busy for five DONE cycles.
    wb_free = 1'b0;
    launch(2'b01, 32'd100, 32'd7, 5'd9);
    @(posedge clk); #1;
    start_E = 1'b0;
    wait_valid(n, gap);
    check("hold_latency", 32'(n), 32'd33);
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (!div_wb_valid || div_wb_rd !== 5'd9 || div_wb_data !== 32'd14 || !div_stall)
        bad = 1'b1;
      @(posedge clk); #1;
    end
    check("hold_stable", {31'b0, bad}, 32'd0);
    wb_free = 1'b1; #1;
    check("hold_write_valid", {31'b0, div_wb_valid}, 32'd1);
    check("hold_write_stall", {31'b0, div_stall}, 32'd1);
    check("hold_write_data", div_wb_data, 32'd14);
    @(posedge clk); #1;
    check("hold_idle_valid", {31'b0, div_wb_valid}, 32'd0);
    check("hold_idle_stall", {31'b0, div_stall}, 32'd0);

    // Reset in the middle of the iteration phase.
    launch(2'b01, 32'd100, 32'd7, 5'd5);
    @(posedge clk); #1;
    start_E = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1; #1;
    check("midrst_valid",   {31'b0, div_wb_valid}, 32'd0);
    check("midrst_rd",      {27'b0, div_wb_rd},    32'd0);
    check("midrst_data",    div_wb_data,           32'd0);
    check("midrst_stall",   {31'b0, div_stall},    32'd0);
    check("midrst_overlap", {31'b0, div_overlap},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_div(2'b01, 32'd9, 32'd3, 5'd3, 32'd3, 33, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
